ascii_hex_decoder: RTL and testbench

Receive-side counterpart to the serial console's ASCII number printer. It consumes the byte stream from `uart_rx` (`data`/`data_strobe`) and parses whitespace- or line-delimited hexadecimal tokens into binary values. Each completed token produces a one-cycle `value_strobe`; malformed or overlong tokens produce a one-cycle `error_strobe`. It sits between `uart_rx` and the top-level register or LED logic in the ulx3s examples.

---
 rtl/ascii_pkg.sv | 19 +
 rtl/ascii_hex_nibble.sv | 30 +++
 rtl/ascii_hex_decoder.sv | 96 +++++++++
 tb/tb_ascii_hex_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared ASCII constants and decoder state encoding for the console
// byte-stream parsers.
package ascii_pkg;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_SP  = 8'h20;
   localparam logic [7:0] ASCII_TAB = 8'h09;
   localparam logic [7:0] ASCII_0   = 8'h30;
   localparam logic [7:0] ASCII_A   = 8'h41;
   localparam logic [7:0] ASCII_a   = 8'h61;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DISCARD = 2'd2
   } dec_state_t;

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational byte classifier: hex digit value, separator and end-of-line flags.
module ascii_hex_nibble
   import ascii_pkg::*;
(
   input  logic [7:0] data,
   output logic       is_hex,
   output logic [3:0] nibble,
   output logic       is_sep,
   output logic       is_eol
);

   always_comb begin
      is_hex = 1'b0;
      nibble = 4'd0;
      if (data >= ASCII_0 && data <= ASCII_0 + 8'd9) begin
         is_hex = 1'b1;
         nibble = 4'(data - ASCII_0);
      end else if (data >= ASCII_A && data <= ASCII_A + 8'd5) begin
         is_hex = 1'b1;
         nibble = 4'(data - ASCII_A + 8'd10);
      end else if (data >= ASCII_a && data <= ASCII_a + 8'd5) begin
         is_hex = 1'b1;
         nibble = 4'(data - ASCII_a + 8'd10);
      end
   end

   assign is_sep = (data == ASCII_SP) || (data == ASCII_TAB);
   assign is_eol = (data == ASCII_CR) || (data == ASCII_LF);

endmodule

// File: rtl/ascii_hex_decoder.sv
// Parses whitespace/line delimited hex tokens from a UART byte stream into
// binary values, flagging malformed or overlong tokens once per line.
module ascii_hex_decoder
   import ascii_pkg::*;
#(
   parameter int MAX_DIGITS = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [7:0]                       data,
   input  logic                             data_strobe,
   output logic [4*MAX_DIGITS-1:0]          value,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  count,
   output logic                             value_strobe,
   output logic                             error_strobe
);

   localparam int W  = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic          is_hex;
   logic [3:0]    nibble;
   logic          is_sep;
   logic          is_eol;

   dec_state_t    state_reg;
   logic [W-1:0]  acc_reg;
   logic [CW-1:0] n_reg;

   ascii_hex_nibble u_nibble (
      .data   (data),
      .is_hex (is_hex),
      .nibble (nibble),
      .is_sep (is_sep),
      .is_eol (is_eol)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         acc_reg      <= '0;
         n_reg        <= '0;
         value        <= '0;
         count        <= '0;
         value_strobe <= 1'b0;
         error_strobe <= 1'b0;
      end else begin
         value_strobe <= 1'b0;
         error_strobe <= 1'b0;
         if (data_strobe) begin
            case (state_reg)
               IDLE: begin
                  if (is_hex) begin
                     acc_reg   <= W'(nibble);
                     n_reg     <= CW'(1);
                     state_reg <= ACCUM;
                  end else if (!is_sep && !is_eol) begin
                     error_strobe <= 1'b1;
                     state_reg    <= DISCARD;
                  end
               end
               ACCUM: begin
                  if (is_hex && n_reg != CW'(MAX_DIGITS)) begin
                     acc_reg <= {acc_reg[W-5:0], nibble};
                     n_reg   <= n_reg + CW'(1);
                  end else if (is_sep || is_eol) begin
                     value        <= acc_reg;
                     count        <= n_reg;
                     value_strobe <= 1'b1;
                     acc_reg      <= '0;
                     n_reg        <= '0;
                     state_reg    <= IDLE;
                  end else begin
                     // Overflow and bad characters both poison the rest of the line.
                     error_strobe <= 1'b1;
                     acc_reg      <= '0;
                     n_reg        <= '0;
                     state_reg    <= DISCARD;
                  end
               end
               DISCARD: begin
                  if (is_eol) begin
                     state_reg <= IDLE;
                  end
               end
               default: begin
                  acc_reg   <= '0;
                  n_reg     <= '0;
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascii_hex_decoder.sv
// Scoreboard bench for ascii_hex_decoder: directed scenarios plus random
// byte streams checked against a token-level reference model.
module tb_ascii_hex_decoder;

   localparam int MAXD = 8;
   localparam int W    = 4 * MAXD;
   localparam int CW   = $clog2(MAXD + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    data = 8'h00;
   logic          data_strobe = 1'b0;
   logic [W-1:0]  value;
   logic [CW-1:0] count;
   logic          value_strobe;
   logic          error_strobe;

   ascii_hex_decoder #(.MAX_DIGITS(MAXD)) dut (
      .clk          (clk),
      .reset        (reset),
      .data         (data),
      .data_strobe  (data_strobe),
      .value        (value),
      .count        (count),
      .value_strobe (value_strobe),
      .error_strobe (error_strobe)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_err;
      logic [W-1:0] v;
      int           c;
      int           cyc;
   } exp_t;

   exp_t         expq[$];
   int           digits[$];
   bit           discarding = 1'b0;
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   logic         rst_q = 1'b1;
   logic [W-1:0] hold_v = '0;
   int           hold_c = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: a token is a list of hex digit values; lines that go bad are skipped.
   function automatic int hex_val(input logic [7:0] b);
      string lo = "0123456789abcdef";
      string up = "0123456789ABCDEF";
      for (int i = 0; i < 16; i++)
         if (b == lo[i] || b == up[i]) return i;
      return -1;
   endfunction

   task automatic emit_value(input int when);
      exp_t e;
      e.is_err = 1'b0;
      e.v      = '0;
      foreach (digits[i]) e.v = (e.v << 4) | W'(digits[i]);
      e.c      = digits.size();
      e.cyc    = when;
      expq.push_back(e);
      $display("[TB] expect value %0h count %0d at cycle %0d", e.v, e.c, when);
      digits.delete();
   endtask

   task automatic emit_err(input int when);
      exp_t e;
      e.is_err = 1'b1;
      e.v      = '0;
      e.c      = 0;
      e.cyc    = when;
      expq.push_back(e);
      $display("[TB] expect error at cycle %0d", when);
      digits.delete();
      discarding = 1'b1;
   endtask

   task automatic model(input logic [7:0] b, input int when);
      int h;
      h = hex_val(b);
      if (b == 8'h0D || b == 8'h0A) begin
         if (!discarding && digits.size() > 0) emit_value(when);
         discarding = 1'b0;
      end else if (b == 8'h20 || b == 8'h09) begin
         if (!discarding && digits.size() > 0) emit_value(when);
      end else if (!discarding) begin
         if (h >= 0 && digits.size() < MAXD) digits.push_back(h);
         else emit_err(when);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      data        = b;
      data_strobe = 1'b1;
      model(b, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         data_strobe = 1'b0;
         data        = 8'($urandom);
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic do_reset(input bit with_byte);
      @(posedge clk);
      #1;
      reset       = 1'b1;
      data_strobe = with_byte;
      data        = "7";
      digits.delete();
      discarding  = 1'b0;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      data_strobe = 1'b0;
   endtask

   function automatic logic [7:0] rand_byte();
      string hx  = "0123456789abcdefABCDEF";
      string bad = "Gxz!-.:_g";
      int r;
      r = $urandom_range(0, 99);
      if (r < 58) return hx[$urandom_range(0, 21)];
      if (r < 75) return ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h09;
      if (r < 90) return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      if (r < 95) return bad[$urandom_range(0, 8)];
      return ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
   endfunction

   // Monitor: reset state, strobe ordering/latency/contents, and value hold between emits.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_q) begin
         check("reset_value", 64'(value), 64'd0);
         check("reset_count", 64'(count), 64'd0);
         check("reset_value_strobe", 64'(value_strobe), 64'd0);
         check("reset_error_strobe", 64'(error_strobe), 64'd0);
         hold_v = '0;
         hold_c = 0;
      end else begin
         if (value_strobe || error_strobe) begin
            check("strobe_exclusive", 64'(value_strobe & error_strobe), 64'd0);
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_strobe actual vs=%0b es=%0b required none (cycle %0d)",
                        value_strobe, error_strobe, cyc);
            end else begin
               e = expq.pop_front();
               $display("[TB] cycle %0d strobe vs=%0b es=%0b value=%0h count=%0d",
                        cyc, value_strobe, error_strobe, value, count);
               check("strobe_kind", 64'(error_strobe), 64'(e.is_err));
               check("strobe_cycle", 64'(cyc), 64'(e.cyc));
               if (!e.is_err) begin
                  hold_v = e.v;
                  hold_c = e.c;
               end
            end
         end
         check("value", 64'(value), 64'(hold_v));
         check("count", 64'(count), 64'(hold_c));
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_strobe actual none required err=%0b value=%0h at cycle %0d",
                     e.is_err, e.v, e.cyc);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      send_str("1A\015", 9);
      idle(3);
      send_str("DEADbeef\015\012", 0);
      idle(3);
      send_str("123456789\0155\015", 0);
      idle(3);
      send_str("1G2 7\0153\012", 0);
      idle(3);
      send_str("12 34\01156\015", 0);
      idle(3);
      send_str("AB", 0);
      do_reset(1'b1);
      send_str("C\015", 0);
      idle(3);
      send_str("FF", 0);
      do_reset(1'b0);
      send_str("\015 \0127\011", 0);
      idle(3);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) != 0);
         send(rand_byte());
         if ($urandom_range(0, 9) >= 7) idle($urandom_range(1, 3));
      end
      send(8'h0D);
      idle(10);
      check("queue_drained", 64'(expq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
